// File: rtl/nes_controller_reader.sv
// NES/SNES-style gamepad poller: latches the controller, clocks out eight
// active-low button bits and publishes them as one active-high byte per frame.
module nes_controller_reader #(
  parameter int unsigned HALF_PERIOD = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  // Wide enough to hold 2*HALF_PERIOD-1 without wrapping.
  localparam int unsigned CntW = $clog2(2 * HALF_PERIOD + 1);

  localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF_PERIOD - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LATCH   = 3'd1;
  localparam logic [2:0] READ_LO = 3'd2;
  localparam logic [2:0] READ_HI = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]      state,    stateNext;
  logic [CntW-1:0] phaseCnt, phaseCntNext;
  logic [2:0]      bitIdx,   bitIdxNext;
  logic [7:0]      shiftReg, shiftNext;

  always_comb begin
    stateNext    = state;
    phaseCntNext = phaseCnt;
    bitIdxNext   = bitIdx;
    shiftNext    = shiftReg;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext    = LATCH;
          phaseCntNext = '0;
          bitIdxNext   = 3'd0;
          shiftNext    = 8'h00;
        end
      end
      LATCH: begin
        if (phaseCnt == LatchLast) begin
          stateNext    = READ_LO;
          phaseCntNext = '0;
          bitIdxNext   = 3'd0;
        end else begin
          phaseCntNext = phaseCnt + CntOne;
        end
      end
      READ_LO: begin
        if (phaseCnt == HalfLast) begin
          // Sample at the very end of the low phase, just before nes_clk rises.
          shiftNext[bitIdx] = ~nes_data;
          phaseCntNext      = '0;
          stateNext         = (bitIdx == 3'd7) ? DONE : READ_HI;
        end else begin
          phaseCntNext = phaseCnt + CntOne;
        end
      end
      READ_HI: begin
        if (phaseCnt == HalfLast) begin
          stateNext    = READ_LO;
          phaseCntNext = '0;
          bitIdxNext   = bitIdx + 3'd1;
        end else begin
          phaseCntNext = phaseCnt + CntOne;
        end
      end
      DONE: begin
        stateNext    = IDLE;
        phaseCntNext = '0;
        bitIdxNext   = 3'd0;
      end
      default: begin
        stateNext    = IDLE;
        phaseCntNext = '0;
        bitIdxNext   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      phaseCnt <= '0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
    end else begin
      state    <= stateNext;
      phaseCnt <= phaseCntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
    end
  end

  // Outputs are registered from the next state so they line up with state cycle-for-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nes_latch <= 1'b0;
      nes_clk   <= 1'b1;
      buttons   <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      nes_latch <= (stateNext == LATCH);
      nes_clk   <= (stateNext != READ_LO);
      valid     <= (stateNext == DONE);
      busy      <= (stateNext != IDLE);
      if (stateNext == DONE) begin
        buttons <= shiftNext;
      end
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: shift-register controller model plus a
// scoreboard of expected frames checked whenever valid pulses.
module tb_nes_controller_reader;

  localparam int unsigned HP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       nes_data = 1'b1;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  nes_controller_reader #(.HALF_PERIOD(HP)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         latchAt;
    int         validAt;
    logic [7:0] btn;
  } exp_t;

  typedef struct {
    logic [7:0] wirePat;
    logic [7:0] expBtn;
  } vec_t;

  exp_t       sbq[$];
  exp_t       e;
  vec_t       vecs[6];
  logic [7:0] wirePat = 8'hFF;
  int         nAssert = 0;
  int         nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller: bit 0 on the wire after latch, next bit after each nes_clk rise.
  int   modelIdx = 0;
  logic modelPrevClk = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (nes_latch) modelIdx = 0;
      else if (nes_clk && !modelPrevClk) modelIdx++;
      modelPrevClk = nes_clk;
      nes_data = (modelIdx < 8) ? wirePat[modelIdx[2:0]] : 1'b1;
    end
  end

  int   rises = 0;
  int   latchCyc = 0;
  int   lastLatchAt = -1;
  logic pClk = 1'b1;
  logic pLatch = 1'b0;
  logic pValid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (nes_latch && !pLatch) begin
        lastLatchAt = cyc;
        rises       = 0;
        latchCyc    = 0;
      end
      if (nes_latch) latchCyc++;
      if (busy && !valid && nes_clk && !pClk) rises++;
      if (valid) begin
        check("valid_width", 32'(pValid), 32'd0);
        if (sbq.size() == 0) begin
          nAssert++;
          nFail++;
          $display("FAIL unexpected_valid: got valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("buttons", 32'(buttons), 32'(e.btn));
          check("valid_cycle", 32'(cyc), 32'(e.validAt));
          check("latch_start", 32'(lastLatchAt), 32'(e.latchAt));
          check("latch_len", 32'(latchCyc), 32'(2 * HP));
          check("clk_rises", 32'(rises), 32'd7);
        end
      end
      pClk   = nes_clk;
      pLatch = nes_latch;
      pValid = valid;
    end
  end

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      nAssert++;
      nFail++;
      $display("FAIL drain_timeout: got %0d frames pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic runFrame(input logic [7:0] wire_, input logic [7:0] expBtn);
    int t;
    @(negedge clk);
    wirePat = wire_;
    start   = 1'b1;
    t       = cyc;
    sbq.push_back('{t + 1, t + 1 + 17 * HP, expBtn});
    @(negedge clk);
    start = 1'b0;
    drain(200);
    repeat (20) @(negedge clk);
    check("buttons_hold", 32'(buttons), 32'(expBtn));
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    vecs[0] = '{8'h5A, 8'hA5};
    vecs[1] = '{8'hFF, 8'h00};
    vecs[2] = '{8'h00, 8'hFF};
    vecs[3] = '{8'hC3, 8'h3C};
    vecs[4] = '{8'h7E, 8'h81};
    vecs[5] = '{8'hF0, 8'h0F};

    repeat (3) @(negedge clk);
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_clk", 32'(nes_clk), 32'd1);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("no_autopoll_busy", 32'(busy), 32'd0);
    check("no_autopoll_latch", 32'(nes_latch), 32'd0);

    foreach (vecs[i]) runFrame(vecs[i].wirePat, vecs[i].expBtn);

    // start re-pulsed mid-frame must be ignored
    @(negedge clk);
    wirePat = 8'h5A;
    start   = 1'b1;
    t       = cyc;
    sbq.push_back('{t + 1, t + 69, 8'hA5});
    @(negedge clk);
    start = 1'b0;
    check("repulse_busy_first", 32'(busy), 32'd1);
    waitCyc(t + 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCyc(t + 40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCyc(t + 69);
    check("repulse_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("repulse_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("repulse_not_queued", 32'(busy), 32'd0);
    drain(50);

    // start held high: frames every 70 cycles
    @(negedge clk);
    wirePat = 8'hC3;
    start   = 1'b1;
    t       = cyc;
    for (int k = 0; k < 5; k++) sbq.push_back('{t + 1 + 70 * k, t + 69 + 70 * k, 8'h3C});
    waitCyc(t + 70);
    check("held_idle_gap", 32'(busy), 32'd0);
    waitCyc(t + 300);
    start = 1'b0;
    drain(200);
    repeat (5) @(negedge clk);
    check("held_stopped", 32'(busy), 32'd0);

    // reset mid-frame aborts without valid
    @(negedge clk);
    wirePat = 8'h00;
    start   = 1'b1;
    t       = cyc;
    @(negedge clk);
    start = 1'b0;
    waitCyc(t + 30);
    reset = 1'b0;
    #1;
    check("abort_latch", 32'(nes_latch), 32'd0);
    check("abort_clk", 32'(nes_clk), 32'd1);
    check("abort_buttons", 32'(buttons), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_buttons_kept", 32'(buttons), 32'd0);
    runFrame(8'h69, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
